// File: rtl/divider_recon_mult.sv
// Divider result checker: rebuilds the dividend n = q*d + r with a radix-2
// shift-add multiplier and flags a zero divisor or an out-of-range remainder.
module divider_recon_mult #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     q,
    input  logic [W-1:0]     d,
    input  logic [W-1:0]     r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   n,
    output logic             d_zero,
    output logic             rem_err,
    output logic             busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    logic [1:0]     state_r;
    logic [2*W-1:0] acc_r;
    logic [2*W-1:0] mcand_r;
    logic [W-1:0]   mplier_r;
    logic [CW-1:0]  cnt_r;
    logic [2*W-1:0] n_r;
    logic           d_zero_r;
    logic           rem_err_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           busy_r;
    logic [2*W-1:0] acc_step_s;
    logic           accept_s;

    // A remainder that is not strictly below the divisor cannot come from a correct division.
    function automatic logic rem_check(input logic [W-1:0] rv, input logic [W-1:0] dv);
        return (rv >= dv);
    endfunction

    function automatic logic zero_check(input logic [W-1:0] dv);
        return (dv == {W{1'b0}});
    endfunction

    assign accept_s = in_valid && in_ready_r && (state_r == IDLE);

    // One shift-add step: conditionally add the shifted multiplicand.
    always_comb begin
        acc_step_s = acc_r;
        if (mplier_r[0]) begin
            acc_step_s = acc_r + mcand_r;
        end else begin
            acc_step_s = acc_r;
        end
    end

    // Control FSM and datapath registers; n only changes when a product completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= {(2*W){1'b0}};
            mcand_r     <= {(2*W){1'b0}};
            mplier_r    <= {W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            n_r         <= {(2*W){1'b0}};
            d_zero_r    <= 1'b0;
            rem_err_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        acc_r       <= {{W{1'b0}}, r};
                        mcand_r     <= {{W{1'b0}}, d};
                        mplier_r    <= q;
                        cnt_r       <= {CW{1'b0}};
                        d_zero_r    <= zero_check(d);
                        rem_err_r   <= rem_check(r, d);
                        state_r     <= CALC;
                        in_ready_r  <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                CALC: begin
                    acc_r    <= acc_step_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    // Fixed-length loop: no early exit even when the multiplier empties.
                    if (cnt_r == LAST_STEP) begin
                        n_r         <= acc_step_s;
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign n         = n_r;
    assign d_zero    = d_zero_r;
    assign rem_err   = rem_err_r;

endmodule

// File: tb/tb_divider_recon_mult.sv
// Directed bench for divider_recon_mult with a scoreboard of expected results.
module tb_divider_recon_mult;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   q;
    logic [W-1:0]   d;
    logic [W-1:0]   r;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] n;
    logic           d_zero;
    logic           rem_err;
    logic           busy;

    typedef struct {
        logic [2*W-1:0] n;
        logic           dz;
        logic           re;
        int             cyc;
    } exp_t;

    exp_t           sb[$];
    int             n_cmp = 0;
    int             n_err = 0;
    int             cyc = 0;
    logic [2*W-1:0] last_n = '0;

    divider_recon_mult #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .d         (d),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n         (n),
        .d_zero    (d_zero),
        .rem_err   (rem_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model_n(input logic [W-1:0] qv, input logic [W-1:0] dv,
                                               input logic [W-1:0] rv);
        return (2*W)'(qv) * (2*W)'(dv) + (2*W)'(rv);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts and ends on a falling edge.
    task automatic run_op(input logic [W-1:0] qv, input logic [W-1:0] dv, input logic [W-1:0] rv,
                          input logic [2*W-1:0] en, input logic edz, input logic ere, input int bp);
        exp_t e;
        bit   got;
        int   k;
        q = qv; d = dv; r = rv;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        check("pre_in_ready", 32'(in_ready), 32'd1);
        tick();
        sb.push_back('{en, edz, ere, cyc});
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_in_ready", 32'(in_ready), 32'd0);
        got = 1'b0;
        k = 0;
        while (!got && k < 20) begin
            if (out_valid) begin
                got = 1'b1;
            end else begin
                check("no_partial_n", 32'(n), 32'(last_n));
                in_valid = 1'($urandom_range(0, 1));
                q = W'($urandom); d = W'($urandom); r = W'($urandom);
                tick();
                k++;
            end
        end
        in_valid = 1'b0;
        if (!got) begin
            check("timeout_out_valid", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("latency", 32'(cyc - e.cyc), 32'd8);
            check("n", 32'(n), 32'(e.n));
            check("d_zero", 32'(d_zero), 32'(e.dz));
            check("rem_err", 32'(rem_err), 32'(e.re));
            for (int i = 0; i < bp; i++) begin
                tick();
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_n", 32'(n), 32'(e.n));
                check("bp_in_ready", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
            tick();
            check("post_out_valid", 32'(out_valid), 32'd0);
            check("post_in_ready", 32'(in_ready), 32'd1);
            check("post_busy", 32'(busy), 32'd0);
            last_n = e.n;
        end
    endtask

    initial begin
        exp_t        e;
        bit          pending;
        int          accepts;
        int          results;
        logic [W-1:0] rq, rd, rr;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        q = '0; d = '0; r = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_n", 32'(n), 32'd0);
        check("rst_d_zero", 32'(d_zero), 32'd0);
        check("rst_rem_err", 32'(rem_err), 32'd0);
        rst = 1'b0;
        tick();

        run_op(8'h2A, 8'h05, 8'h03, 16'h00D5, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 8'hFF, 16'hFF00, 1'b0, 1'b1, 0);
        run_op(8'h10, 8'h00, 8'h07, 16'h0007, 1'b1, 1'b1, 0);
        run_op(8'h2A, 8'h05, 8'h03, 16'h00D5, 1'b0, 1'b0, 5);
        for (int i = 0; i < 3; i++) begin
            rq = W'($urandom); rd = W'($urandom); rr = W'($urandom);
            run_op(rq, rd, rr, model_n(rq, rd, rr), (rd == '0), (rr >= rd), i);
        end
        run_op(8'h2A, 8'h05, 8'h03, 16'h00D5, 1'b0, 1'b0, 0);

        // Reset during CALC step 4.
        q = 8'h2A; d = 8'h05; r = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_n", 32'(n), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_n = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("no_stale_out_valid", 32'(out_valid), 32'd0);
        end
        check("after_rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back with in_valid and out_ready tied high.
        q = 8'd3; d = 8'd7; r = 8'd2; in_valid = 1'b1; out_ready = 1'b1;
        pending = 1'b0; accepts = 0; results = 0;
        for (int k = 0; k < 60 && results < 2; k++) begin
            if (pending) begin
                sb.push_back('{model_n(q, d, r), (d == '0), (r >= d), cyc});
                accepts++;
                q = 8'd0; d = 8'd9; r = 8'd8;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("b2b_unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("b2b_latency", 32'(cyc - e.cyc), 32'd8);
                    check("b2b_n", 32'(n), 32'(results == 0 ? 16'h0017 : 16'h0008));
                    check("b2b_rem_err", 32'(rem_err), 32'd0);
                end
                results++;
                if (results == 2) in_valid = 1'b0;
            end
            pending = in_valid && in_ready;
            tick();
        end
        check("b2b_results", 32'(results), 32'd2);
        check("b2b_accepts", 32'(accepts), 32'd2);
        repeat (12) tick();
        check("b2b_idle_out_valid", 32'(out_valid), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
